multi_cycle_control_unit: RTL and testbench

Multi-cycle control FSM for the MultiCPU datapath. It sequences each instruction through IF/ID/EXE/MEM/WB, and drives PC, IR, register-file, ALU and memory enables. It also drives `PCSrc`, which selects the next PC among PC+4, branch target, `rs` (jr) and the jump-address path `{PC4[31:28], addr<<2}`. It sits beside the datapath; the instruction register feeds `Opcode`, and the ALU feeds `Zero`/`Sign`.

---
 rtl/multi_cycle_control_unit_pkg.sv | 70 +++++++
 rtl/multi_cycle_control_unit_control_signal_decoder.sv | 122 ++++++++++++
 rtl/multi_cycle_control_unit.sv | 84 ++++++++
 tb/tb_multi_cycle_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_unit_pkg.sv
// rtl/multi_cycle_control_unit_pkg.sv - shared opcode, state and mux-select codes for the MultiCPU
package multi_cycle_control_unit_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_LD  = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLL) ||
           (op == OP_SLT) || is_imm_op(op);
  endfunction

  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_ORI:          return ALU_OR;
      OP_SLL:          return ALU_SLL;
      OP_SLT, OP_SLTI: return ALU_SLT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_control_signal_decoder.sv
// rtl/multi_cycle_control_unit_control_signal_decoder.sv - combinational State+Opcode to datapath control decode
module control_signal_decoder
  import multi_cycle_control_unit_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        sign_i,
  output logic        pc_wre_o,
  output logic        ir_wre_o,
  output logic        ins_mem_rw_o,
  output logic        reg_wre_o,
  output logic        m_rd_o,
  output logic        m_wr_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  output logic        ext_sel_o,
  output logic        db_data_src_o,
  output logic        wr_reg_d_src_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  pc_src_o,
  output logic [2:0]  alu_op_o
);

  logic taken;

  always_comb begin
    case (opcode_i)
      OP_BEQ:  taken = zero_i;
      OP_BNE:  taken = ~zero_i;
      OP_BLTZ: taken = sign_i;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_wre_o       = 1'b0;
    ir_wre_o       = 1'b0;
    ins_mem_rw_o   = 1'b0;
    reg_wre_o      = 1'b0;
    m_rd_o         = 1'b0;
    m_wr_o         = 1'b0;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 1'b0;
    ext_sel_o      = 1'b0;
    db_data_src_o  = 1'b0;
    wr_reg_d_src_o = 1'b0;
    reg_dst_o      = REGDST_RA;
    pc_src_o       = PCSRC_PC4;
    alu_op_o       = ALU_ADD;

    case (state_i)
      sIF: begin
        ins_mem_rw_o = 1'b1;
        ir_wre_o     = 1'b1;
      end
      sID: begin
        case (opcode_i)
          OP_J: begin
            pc_wre_o = 1'b1;
            pc_src_o = PCSRC_JUMP;
          end
          OP_JR: begin
            pc_wre_o = 1'b1;
            pc_src_o = PCSRC_RS;
          end
          OP_JAL: begin
            pc_wre_o       = 1'b1;
            pc_src_o       = PCSRC_JUMP;
            reg_wre_o      = 1'b1;
            reg_dst_o      = REGDST_RA;
            wr_reg_d_src_o = 1'b0;
          end
          OP_HALT, OP_BEQ, OP_BNE, OP_BLTZ, OP_LW, OP_SW: ;
          default: begin
            // Unknown opcodes retire here as a nop; real ALU ops go on to execute.
            pc_wre_o = ~is_alu_op(opcode_i);
          end
        endcase
      end
      sEXE_AL, sWB_AL: begin
        alu_op_o    = alu_op_for(opcode_i);
        alu_src_a_o = (opcode_i == OP_SLL);
        alu_src_b_o = is_imm_op(opcode_i);
        ext_sel_o   = (opcode_i == OP_ADDIU) || (opcode_i == OP_SLTI);
        if (state_i == sWB_AL) begin
          reg_wre_o      = 1'b1;
          wr_reg_d_src_o = 1'b1;
          reg_dst_o      = is_imm_op(opcode_i) ? REGDST_RT : REGDST_RD;
          pc_wre_o       = 1'b1;
        end
      end
      sEXE_BR: begin
        alu_op_o  = ALU_SUB;
        ext_sel_o = 1'b1;
        pc_wre_o  = 1'b1;
        pc_src_o  = taken ? PCSRC_BRANCH : PCSRC_PC4;
      end
      sEXE_LS: begin
        alu_src_b_o = 1'b1;
        ext_sel_o   = 1'b1;
      end
      sMEM: begin
        if (opcode_i == OP_SW) begin
          m_wr_o   = 1'b1;
          pc_wre_o = 1'b1;
        end else begin
          m_rd_o = 1'b1;
        end
      end
      sWB_LD: begin
        reg_wre_o      = 1'b1;
        db_data_src_o  = 1'b1;
        wr_reg_d_src_o = 1'b1;
        reg_dst_o      = REGDST_RT;
        pc_wre_o       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - multi-cycle IF/ID/EXE/MEM/WB sequencer for the MultiCPU datapath
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        Sign,
  output logic [2:0]  State,
  output logic        PCWre,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        RegWre,
  output logic        mRD,
  output logic        mWR,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        ExtSel,
  output logic        DBDataSrc,
  output logic        WrRegDSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp
);

  state_t state_q, state_d;

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= sIF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = sIF;
    case (state_q)
      sIF: state_d = sID;
      sID: begin
        case (opcode_i_sel(Opcode))
          2'd1:    state_d = sEXE_BR;
          2'd2:    state_d = sEXE_LS;
          2'd3:    state_d = sEXE_AL;
          default: state_d = sIF;
        endcase
      end
      sEXE_AL: state_d = sWB_AL;
      sEXE_LS: state_d = sMEM;
      sMEM:    state_d = (Opcode == OP_LW) ? sWB_LD : sIF;
      default: state_d = sIF;
    endcase
  end

  // Instruction class after decode: 0 retires in ID, 1 branch, 2 load/store, 3 ALU.
  function automatic logic [1:0] opcode_i_sel(input logic [5:0] op);
    if ((op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ)) return 2'd1;
    if ((op == OP_LW) || (op == OP_SW))                      return 2'd2;
    if (is_alu_op(op))                                      return 2'd3;
    return 2'd0;
  endfunction

  assign State = state_q;

  control_signal_decoder u_decoder (
    .state_i        (state_q),
    .opcode_i       (Opcode),
    .zero_i         (Zero),
    .sign_i         (Sign),
    .pc_wre_o       (PCWre),
    .ir_wre_o       (IRWre),
    .ins_mem_rw_o   (InsMemRW),
    .reg_wre_o      (RegWre),
    .m_rd_o         (mRD),
    .m_wr_o         (mWR),
    .alu_src_a_o    (ALUSrcA),
    .alu_src_b_o    (ALUSrcB),
    .ext_sel_o      (ExtSel),
    .db_data_src_o  (DBDataSrc),
    .wr_reg_d_src_o (WrRegDSrc),
    .reg_dst_o      (RegDst),
    .pc_src_o       (PCSrc),
    .alu_op_o       (ALUOp)
  );

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - self-checking bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero, Sign;
  logic [2:0] State;
  logic       PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  multi_cycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Sign(Sign),
    .State(State), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
    .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp)
  );

  typedef struct packed {
    logic [2:0] st;
    logic pcwre, irwre, insmem, regwre, mrd, mwr, srca, srcb, ext, dbsrc, wrsrc;
    logic [1:0] regdst, pcsrc;
    logic [2:0] aluop;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       z, s;
    int         cpi;
    int         n_pcwre;
    logic [1:0] pcsrc_last;
  } vec_t;

  obs_t exp_q[$];

  function automatic obs_t observe();
    obs_t o;
    o = {State, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
         ExtSel, DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: expected per-cycle control word for one whole instruction.
  task automatic build_trace(input logic [5:0] op, input logic z, input logic s);
    obs_t e;
    logic imm, taken;
    logic [2:0] alu;
    exp_q.delete();
    e = '0; e.st = 3'd0; e.irwre = 1; e.insmem = 1;
    exp_q.push_back(e);
    e = '0; e.st = 3'd1;
    case (op)
      6'b111000: begin e.pcwre = 1; e.pcsrc = 2'b11; exp_q.push_back(e); end
      6'b111001: begin e.pcwre = 1; e.pcsrc = 2'b10; exp_q.push_back(e); end
      6'b111010: begin
        e.pcwre = 1; e.pcsrc = 2'b11; e.regwre = 1; e.regdst = 2'b00; e.wrsrc = 0;
        exp_q.push_back(e);
      end
      6'b111111: exp_q.push_back(e);
      6'b110100, 6'b110101, 6'b110110: begin
        exp_q.push_back(e);
        taken = (op == 6'b110100) ? z : (op == 6'b110101) ? !z : s;
        e = '0; e.st = 3'd5; e.aluop = 3'b001; e.ext = 1; e.pcwre = 1;
        e.pcsrc = taken ? 2'b01 : 2'b00;
        exp_q.push_back(e);
      end
      6'b110000, 6'b110001: begin
        exp_q.push_back(e);
        e = '0; e.st = 3'd2; e.srcb = 1; e.ext = 1; exp_q.push_back(e);
        e = '0; e.st = 3'd3;
        if (op == 6'b110001) e.mrd = 1; else begin e.mwr = 1; e.pcwre = 1; end
        exp_q.push_back(e);
        if (op == 6'b110001) begin
          e = '0; e.st = 3'd4; e.regwre = 1; e.dbsrc = 1; e.wrsrc = 1;
          e.regdst = 2'b01; e.pcwre = 1;
          exp_q.push_back(e);
        end
      end
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b100110, 6'b100111: begin
        exp_q.push_back(e);
        case (op)
          6'b000001:            alu = 3'b001;
          6'b010000, 6'b010001: alu = 3'b100;
          6'b010010:            alu = 3'b011;
          6'b011000:            alu = 3'b010;
          6'b100110, 6'b100111: alu = 3'b110;
          default:              alu = 3'b000;
        endcase
        imm = (op == 6'b000010) || (op == 6'b010001) || (op == 6'b010010) || (op == 6'b100111);
        e = '0; e.st = 3'd6; e.aluop = alu; e.srca = (op == 6'b011000); e.srcb = imm;
        e.ext = (op == 6'b000010) || (op == 6'b100111);
        exp_q.push_back(e);
        e.st = 3'd7; e.regwre = 1; e.wrsrc = 1; e.dbsrc = 0;
        e.regdst = imm ? 2'b01 : 2'b10; e.pcwre = 1; e.pcsrc = 2'b00;
        exp_q.push_back(e);
      end
      default: begin e.pcwre = 1; e.pcsrc = 2'b00; exp_q.push_back(e); end
    endcase
  endtask

  // Entered at a negedge with the DUT in sIF; leaves at the negedge of the next sIF.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
    build_trace(op, z, s);
    Opcode = op; Zero = z; Sign = s;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      check($sformatf("trace op=%b z=%0b s=%0b cyc=%0d", op, z, s, i), 32'(observe()), 32'(exp_q[i]));
      @(negedge CLK);
    end
  endtask

  vec_t vecs[15];
  logic [5:0] defined_ops[18] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                  6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
                                  6'b110001, 6'b110100, 6'b110101, 6'b110110, 6'b111000,
                                  6'b111001, 6'b111010, 6'b111111};

  initial begin
    obs_t if_set;
    int cycles, npc;
    logic [1:0] last_src;
    logic [5:0] rop;

    vecs[0]  = '{6'b000000, 0, 0, 4, 1, 2'b00};
    vecs[1]  = '{6'b110001, 0, 0, 5, 1, 2'b00};
    vecs[2]  = '{6'b110000, 0, 0, 4, 1, 2'b00};
    vecs[3]  = '{6'b110100, 1, 0, 3, 1, 2'b01};
    vecs[4]  = '{6'b110100, 0, 0, 3, 1, 2'b00};
    vecs[5]  = '{6'b110101, 1, 0, 3, 1, 2'b00};
    vecs[6]  = '{6'b110101, 0, 1, 3, 1, 2'b01};
    vecs[7]  = '{6'b110110, 0, 1, 3, 1, 2'b01};
    vecs[8]  = '{6'b110110, 1, 0, 3, 1, 2'b00};
    vecs[9]  = '{6'b111000, 0, 0, 2, 1, 2'b11};
    vecs[10] = '{6'b111001, 0, 0, 2, 1, 2'b10};
    vecs[11] = '{6'b111010, 0, 0, 2, 1, 2'b11};
    vecs[12] = '{6'b000111, 0, 0, 2, 1, 2'b00};
    vecs[13] = '{6'b011000, 0, 0, 4, 1, 2'b00};
    vecs[14] = '{6'b111111, 0, 0, 2, 0, 2'b00};

    Reset = 1'b1; Opcode = 6'b000000; Zero = 1'b0; Sign = 1'b0;
    if_set = '0; if_set.irwre = 1; if_set.insmem = 1;
    repeat (2) begin
      @(negedge CLK);
      check("reset_state", 32'(observe()), 32'(if_set));
    end
    Reset = 1'b0;

    run_instr(6'b000000, 0, 0);

    foreach (vecs[k]) begin
      Opcode = vecs[k].op; Zero = vecs[k].z; Sign = vecs[k].s;
      cycles = 0; npc = 0; last_src = 2'b00;
      do begin
        #1;
        if (PCWre) begin npc++; last_src = PCSrc; end
        @(negedge CLK);
        cycles++;
      end while (State != 3'd0 && cycles < 10);
      check($sformatf("cpi op=%b", vecs[k].op), cycles, vecs[k].cpi);
      check($sformatf("pcwre_count op=%b", vecs[k].op), npc, vecs[k].n_pcwre);
      if (vecs[k].n_pcwre > 0)
        check($sformatf("pcsrc op=%b z=%0b s=%0b", vecs[k].op, vecs[k].z, vecs[k].s),
              32'(last_src), 32'(vecs[k].pcsrc_last));
    end

    Opcode = 6'b111111;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("halt_state c%0d", i), 32'(State), (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("halt_pcwre c%0d", i), 32'(PCWre), 32'd0);
      @(negedge CLK);
    end

    Opcode = 6'b110000;
    repeat (3) @(negedge CLK);
    #1;
    check("sw_in_mem_state", 32'(State), 32'd3);
    check("sw_in_mem_mwr", 32'(mWR), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    check("reset_mid_sw_state", 32'(State), 32'd0);
    check("reset_mid_sw_mwr", 32'(mWR), 32'd0);
    @(negedge CLK);
    check("reset_held_obs", 32'(observe()), 32'(if_set));
    Reset = 1'b0;

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
      else                           rop = defined_ops[$urandom_range(0, 17)];
      run_instr(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
